// File: rtl/pe_array_pkg.sv
// Shared types for the pe_array psum path: lane/row types and collector FSM states.
package pe_array_pkg;

  localparam int COLS   = 3;
  localparam int PSUM_W = 48;

  typedef logic [PSUM_W-1:0] psum_t;
  typedef psum_t psum_row_t [0:COLS-1];

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/psum_fifo.sv
// Synchronous row FIFO. The read port shows the head entry; when empty it keeps
// showing the most recently popped entry, so the data output never changes while
// nothing is available.
module psum_fifo #(
  parameter int WIDTH = 145,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_q, rd_q;
  logic [AW-1:0]    rd_idx, prev_idx;
  logic             do_push, do_pop;

  assign empty    = (wr_q == rd_q);
  assign full     = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign do_pop   = pop && !empty;
  // A simultaneous pop frees the slot, so a write into a full FIFO still lands.
  assign do_push  = push && (!full || do_pop);
  assign rd_idx   = rd_q[AW-1:0];
  assign prev_idx = rd_idx - 1'b1;
  assign rdata    = empty ? mem[prev_idx] : mem[rd_idx];

  // Storage and pointer update; storage is cleared so the held output reads 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_q[AW-1:0]] <= wdata;
        wr_q              <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/psum_deskew_collector.sv
// De-skews diagonal psum output of pe_array, frames one job of num_vecs rows and
// buffers rows toward writeback. The array cannot stall, so a full FIFO drops
// rows and raises the sticky overflow flag.
//
// state   | meaning
// IDLE    | no job; waiting for in_start with num_vecs != 0
// WAIT    | counting down array latency plus deskew depth
// CAPTURE | one aligned row per cycle pushed into the FIFO
module psum_deskew_collector #(
  parameter int COLS      = 3,
  parameter int PSUM_W    = 48,
  parameter int ARRAY_LAT = 3,
  parameter int VEC_W     = 8,
  parameter int DEPTH     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_start,
  input  logic [VEC_W-1:0]       num_vecs,
  input  logic [COLS*PSUM_W-1:0] psums,
  output logic [COLS*PSUM_W-1:0] out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   overflow,
  output logic                   start_err
);

  import pe_array_pkg::*;

  localparam int ROW_W     = COLS * PSUM_W;
  localparam int WAIT_LOAD = ARRAY_LAT + COLS - 1;
  localparam int WCW       = $clog2(WAIT_LOAD + 1);

  state_t           state_q, state_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic [VEC_W-1:0] row_q, row_d, nv_q, nv_d;
  logic             push, push_last, pop, full, empty;
  logic             ovf_q, serr_q;
  logic [ROW_W-1:0] aligned;
  logic [ROW_W:0]   rdata;

  // Lane c is delayed COLS-1-c cycles so every lane of a row lines up with the last column.
  for (genvar c = 0; c < COLS; c++) begin : g_lane
    localparam int D = COLS - 1 - c;
    if (D == 0) begin : g_direct
      assign aligned[c*PSUM_W +: PSUM_W] = psums[c*PSUM_W +: PSUM_W];
    end else begin : g_dly
      logic [PSUM_W-1:0] sr [D];
      // Per-lane shift register.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int k = 0; k < D; k++) sr[k] <= '0;
        end else begin
          sr[0] <= psums[c*PSUM_W +: PSUM_W];
          for (int k = 1; k < D; k++) sr[k] <= sr[k-1];
        end
      end
      assign aligned[c*PSUM_W +: PSUM_W] = sr[D-1];
    end
  end

  // FSM state, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wait_q  <= '0;
      row_q   <= '0;
      nv_q    <= '0;
      ovf_q   <= 1'b0;
      serr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      row_q   <= row_d;
      nv_q    <= nv_d;
      ovf_q   <= ovf_q | (push && full && !pop);
      serr_q  <= serr_q | (in_start && (state_q != IDLE));
    end
  end

  // Next-state logic. The wait count holds WAIT_LOAD in the first WAIT cycle and
  // would reach 1 in the first CAPTURE cycle, i.e. WAIT_LOAD cycles after in_start.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    row_d     = row_q;
    nv_d      = nv_q;
    push      = 1'b0;
    push_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_start && (num_vecs != '0)) begin
          nv_d    = num_vecs;
          wait_d  = WCW'(WAIT_LOAD);
          row_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        wait_d = wait_q - 1'b1;
        if (wait_q <= WCW'(2)) state_d = CAPTURE;
      end
      CAPTURE: begin
        push      = 1'b1;
        push_last = (row_q == nv_q - 1'b1);
        row_d     = row_q + 1'b1;
        if (push_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop = !empty && out_ready;

  psum_fifo #(
    .WIDTH (ROW_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata ({push_last, aligned}),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  assign out_data  = rdata[ROW_W-1:0];
  assign out_last  = rdata[ROW_W];
  assign out_valid = !empty;
  assign busy      = (state_q != IDLE);
  assign overflow  = ovf_q;
  assign start_err = serr_q;

endmodule

// File: tb/tb_psum_deskew_collector.sv
// Directed bench for psum_deskew_collector: a vector table for a basic job and a
// zero-length start, plus hand sequences for stall, start-while-busy, overflow
// and mid-job reset.
module tb_psum_deskew_collector;

  localparam int COLS = 3;
  localparam int PW   = 48;
  localparam int W    = COLS * PW;

  logic         clk, rst, in_start, out_ready;
  logic [7:0]   num_vecs;
  logic [W-1:0] psums, out_data;
  logic         out_valid, out_last, busy, overflow, start_err;

  psum_deskew_collector #(
    .COLS(3), .PSUM_W(48), .ARRAY_LAT(3), .VEC_W(8), .DEPTH(8)
  ) dut (
    .clk(clk), .rst(rst), .in_start(in_start), .num_vecs(num_vecs),
    .psums(psums), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_last(out_last), .busy(busy),
    .overflow(overflow), .start_err(start_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic start;
    int   nv;
    logic ready;
    logic e_valid;
    logic e_last;
    logic e_busy;
    int   e_row;
  } vec_t;

  vec_t tbl [13];
  int   n_chk, n_pass, cyc, job_t, job_n;
  logic job_on;

  // Model of pe_array output: lane c of row m is 100*m+c in cycle T+3+m+c.
  function automatic logic [W-1:0] gen_psums(int cy);
    logic [W-1:0] v;
    int m;
    v = '0;
    for (int c = 0; c < COLS; c++) begin
      m = cy - job_t - 3 - c;
      if (job_on && m >= 0 && m < job_n) v[c*PW +: PW] = PW'(100*m + c);
    end
    return v;
  endfunction

  function automatic logic [W-1:0] exp_row(int r);
    logic [W-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*PW +: PW] = PW'(100*r + c);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    in_start = 1'b0;
    psums = gen_psums(cyc);
  endtask

  task automatic start_job(input int n);
    in_start = 1'b1;
    num_vecs = 8'(n);
    job_t    = cyc;
    job_n    = n;
    job_on   = 1'b1;
    psums    = gen_psums(cyc);
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step();
      out_ready = tbl[i].ready;
      if (tbl[i].start) begin
        if (tbl[i].nv != 0) start_job(tbl[i].nv);
        else begin
          in_start = 1'b1;
          num_vecs = 8'd0;
        end
      end
      chk($sformatf("tbl%0d valid", i), W'(out_valid), W'(tbl[i].e_valid));
      chk($sformatf("tbl%0d busy", i), W'(busy), W'(tbl[i].e_busy));
      chk($sformatf("tbl%0d overflow", i), W'(overflow), W'(0));
      chk($sformatf("tbl%0d start_err", i), W'(start_err), W'(0));
      if (tbl[i].e_valid) chk($sformatf("tbl%0d last", i), W'(out_last), W'(tbl[i].e_last));
      if (tbl[i].e_row >= 0) chk($sformatf("tbl%0d data", i), out_data, exp_row(tbl[i].e_row));
    end
  endtask

  initial begin
    n_chk = 0; n_pass = 0; cyc = 0; job_t = 0; job_n = 0; job_on = 1'b0;
    rst = 1'b1; in_start = 1'b0; num_vecs = '0; out_ready = 1'b1; psums = '0;

    tbl[0]  = '{1'b1, 3, 1'b1, 1'b0, 1'b0, 1'b0, -1};
    tbl[1]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, -1};
    tbl[2]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, -1};
    tbl[3]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, -1};
    tbl[4]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, -1};
    tbl[5]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, -1};
    tbl[6]  = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1,  0};
    tbl[7]  = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b1,  1};
    tbl[8]  = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0,  2};
    tbl[9]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, -1};
    tbl[10] = '{1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, -1};
    tbl[11] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, -1};
    tbl[12] = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, -1};

    step();
    step();
    chk("reset valid", W'(out_valid), W'(0));
    chk("reset busy", W'(busy), W'(0));
    chk("reset last", W'(out_last), W'(0));
    chk("reset data", out_data, '0);
    chk("reset overflow", W'(overflow), W'(0));
    chk("reset start_err", W'(start_err), W'(0));
    rst = 1'b0;

    // basic job then a zero-length start
    run_table(0, 12);

    // backpressure: ready held low until T+20
    step();
    out_ready = 1'b0;
    start_job(3);
    for (int k = 1; k <= 23; k++) begin
      step();
      if (k == 20) out_ready = 1'b1;
      if (k >= 6 && k <= 20) begin
        chk("stall valid", W'(out_valid), W'(1));
        chk("stall data", out_data, exp_row(0));
        chk("stall last", W'(out_last), W'(0));
      end
      if (k == 21) chk("bp row1", out_data, exp_row(1));
      if (k == 22) begin
        chk("bp row2", out_data, exp_row(2));
        chk("bp last", W'(out_last), W'(1));
      end
      if (k == 23) begin
        chk("bp drained", W'(out_valid), W'(0));
        chk("bp overflow", W'(overflow), W'(0));
      end
    end

    // start while busy, then a 1-row job right after busy falls
    step();
    start_job(3);
    for (int k = 1; k <= 15; k++) begin
      step();
      if (k == 2) begin
        in_start = 1'b1;
        num_vecs = 8'd5;
      end
      if (k == 2) chk("serr before", W'(start_err), W'(0));
      if (k == 3) chk("serr set", W'(start_err), W'(1));
      if (k >= 6 && k <= 8) begin
        chk("sb valid", W'(out_valid), W'(1));
        chk("sb data", out_data, exp_row(k - 6));
        chk("sb last", W'(out_last), W'(k == 8));
      end
      if (k == 7) chk("sb busy", W'(busy), W'(1));
      if (k == 8) begin
        chk("sb idle", W'(busy), W'(0));
        start_job(1);
      end
      if (k == 9) chk("restart busy", W'(busy), W'(1));
      if (k == 14) begin
        chk("one valid", W'(out_valid), W'(1));
        chk("one data", out_data, exp_row(0));
        chk("one last", W'(out_last), W'(1));
      end
      if (k == 15) begin
        chk("one drained", W'(out_valid), W'(0));
        chk("serr sticky", W'(start_err), W'(1));
      end
    end

    // overflow: 10 rows into 8 entries with no reader
    step();
    out_ready = 1'b0;
    start_job(10);
    for (int k = 1; k <= 24; k++) begin
      step();
      if (k == 13) chk("ovf not yet", W'(overflow), W'(0));
      if (k == 15) begin
        chk("ovf set", W'(overflow), W'(1));
        chk("ovf idle", W'(busy), W'(0));
        chk("ovf head", out_data, exp_row(0));
      end
      if (k == 16) out_ready = 1'b1;
      if (k >= 16 && k <= 23) begin
        chk("ovf valid", W'(out_valid), W'(1));
        chk("ovf data", out_data, exp_row(k - 16));
        chk("ovf last", W'(out_last), W'(0));
      end
      if (k == 24) begin
        chk("ovf drained", W'(out_valid), W'(0));
        chk("ovf hold data", out_data, exp_row(7));
        chk("ovf sticky", W'(overflow), W'(1));
      end
    end

    // reset in the middle of CAPTURE
    step();
    out_ready = 1'b1;
    start_job(3);
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k == 6) chk("rst pre row0", out_data, exp_row(0));
      if (k == 7) rst = 1'b1;
      if (k == 8) begin
        rst = 1'b0;
        job_on = 1'b0;
        chk("midrst valid", W'(out_valid), W'(0));
        chk("midrst busy", W'(busy), W'(0));
        chk("midrst last", W'(out_last), W'(0));
        chk("midrst data", out_data, '0);
        chk("midrst overflow", W'(overflow), W'(0));
        chk("midrst start_err", W'(start_err), W'(0));
      end
    end
    step();
    chk("postrst empty", W'(out_valid), W'(0));

    // fresh job after reset
    run_table(0, 9);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
